// File: rtl/intra4x4_mode_sched_if.sv
// Datapath-side bundle of the 4x4 intra mode scheduler: neighbour fetch, predictor
// enable, SAD return and per-sub-block result.
interface intra4x4_mode_sched_if #(
  parameter int unsigned COST_W = 16,
  parameter int unsigned MB_X_W = 7,
  parameter int unsigned MB_Y_W = 6
);
  // Neighbour fetch (MB position travels with the request so the fetcher can address lines)
  logic              nb_req;
  logic [3:0]        nb_blk;
  logic [MB_X_W-1:0] nb_mb_x;
  logic [MB_Y_W-1:0] nb_mb_y;
  logic              nb_ack;

  logic              pred_en;
  logic [3:0]        pred_mode;

  logic              cost_valid;
  logic [COST_W-1:0] cost;

  logic              best_valid;
  logic [3:0]        best_blk;
  logic [3:0]        best_mode;
  logic [COST_W-1:0] best_cost;

  modport master (
    output nb_req,
    output nb_blk,
    output nb_mb_x,
    output nb_mb_y,
    input  nb_ack,
    output pred_en,
    output pred_mode,
    input  cost_valid,
    input  cost,
    output best_valid,
    output best_blk,
    output best_mode,
    output best_cost
  );

  modport slave (
    input  nb_req,
    input  nb_blk,
    input  nb_mb_x,
    input  nb_mb_y,
    output nb_ack,
    input  pred_en,
    input  pred_mode,
    output cost_valid,
    output cost,
    input  best_valid,
    input  best_blk,
    input  best_mode,
    input  best_cost
  );
endinterface

// File: rtl/intra4x4_mode_sched.sv
// Sequences the 4x4 intra mode search over the 16 luma sub-blocks of one macroblock and
// reports the minimum-SAD mode per sub-block. Optional INTRA4X4_EARLY_TERM_EN stops early.
module intra4x4_mode_sched #(
  parameter int unsigned WIDTH     = 1280,
  parameter int unsigned LENGTH    = 720,
  parameter int unsigned NUM_MODES = 9,
  parameter int unsigned COST_W    = 16,
  parameter int unsigned ET_THRESH = 64
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          start,
  input  logic [$clog2(WIDTH/16)-1:0]   mb_x,
  input  logic [$clog2(LENGTH/16)-1:0]  mb_y,
  intra4x4_mode_sched_if.master         dp,
  output logic                          busy,
  output logic                          done
);

  localparam int unsigned MbXW = $clog2(WIDTH / 16);
  localparam int unsigned MbYW = $clog2(LENGTH / 16);
  localparam logic [3:0]  LastMode = 4'(NUM_MODES - 1);
  localparam logic [3:0]  LastBlk  = 4'd15;
  localparam logic [COST_W-1:0] EtThresh = COST_W'(ET_THRESH);

`ifdef INTRA4X4_EARLY_TERM_EN
  localparam bit EarlyTermEn = 1'b1;
`else
  localparam bit EarlyTermEn = 1'b0;
`endif

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StPred,
    StWait,
    StDecide,
    StDone
  } state_e;

  state_e            state_q, state_d;
  logic [3:0]        blk_q, blk_d;
  logic [3:0]        mode_q, mode_d;
  logic [COST_W-1:0] min_cost_q, min_cost_d;
  logic [3:0]        min_mode_q, min_mode_d;
  logic [MbXW-1:0]   mb_x_q, mb_x_d;
  logic [MbYW-1:0]   mb_y_q, mb_y_d;
  // Last reported result, shown on best_* between pulses
  logic [3:0]        held_blk_q, held_blk_d;
  logic [3:0]        held_mode_q, held_mode_d;
  logic [COST_W-1:0] held_cost_q, held_cost_d;

  logic              nb_req, pred_en, best_valid;
  logic [3:0]        nb_blk, pred_mode, best_blk, best_mode;
  logic [COST_W-1:0] best_cost;
  logic              cost_lt_min, et_hit;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      blk_q       <= '0;
      mode_q      <= '0;
      min_cost_q  <= '0;
      min_mode_q  <= '0;
      mb_x_q      <= '0;
      mb_y_q      <= '0;
      held_blk_q  <= '0;
      held_mode_q <= '0;
      held_cost_q <= '0;
    end else begin
      state_q     <= state_d;
      blk_q       <= blk_d;
      mode_q      <= mode_d;
      min_cost_q  <= min_cost_d;
      min_mode_q  <= min_mode_d;
      mb_x_q      <= mb_x_d;
      mb_y_q      <= mb_y_d;
      held_blk_q  <= held_blk_d;
      held_mode_q <= held_mode_d;
      held_cost_q <= held_cost_d;
    end
  end

  assign cost_lt_min = dp.cost < min_cost_q;
  assign et_hit      = EarlyTermEn && (dp.cost < EtThresh);

  always_comb begin
    state_d     = state_q;
    blk_d       = blk_q;
    mode_d      = mode_q;
    min_cost_d  = min_cost_q;
    min_mode_d  = min_mode_q;
    mb_x_d      = mb_x_q;
    mb_y_d      = mb_y_q;
    held_blk_d  = held_blk_q;
    held_mode_d = held_mode_q;
    held_cost_d = held_cost_q;

    nb_req      = 1'b0;
    nb_blk      = '0;
    pred_en     = 1'b0;
    pred_mode   = '0;
    best_valid  = 1'b0;
    best_blk    = held_blk_q;
    best_mode   = held_mode_q;
    best_cost   = held_cost_q;
    done        = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          mb_x_d  = mb_x;
          mb_y_d  = mb_y;
          blk_d   = '0;
          state_d = StFetch;
        end
      end

      StFetch: begin
        nb_req = 1'b1;
        nb_blk = blk_q;
        if (dp.nb_ack) begin
          mode_d     = '0;
          min_cost_d = '1;
          min_mode_d = '0;
          state_d    = StPred;
        end
      end

      StPred: begin
        pred_en   = 1'b1;
        pred_mode = mode_q;
        state_d   = StWait;
      end

      StWait: begin
        if (dp.cost_valid) begin
          // Strict compare: on a tie the earlier (lower-index) mode stays
          if (cost_lt_min) begin
            min_cost_d = dp.cost;
            min_mode_d = mode_q;
          end
          if ((mode_q == LastMode) || et_hit) begin
            state_d = StDecide;
          end else begin
            mode_d  = mode_q + 4'd1;
            state_d = StPred;
          end
        end
      end

      StDecide: begin
        best_valid  = 1'b1;
        best_blk    = blk_q;
        best_mode   = min_mode_q;
        best_cost   = min_cost_q;
        held_blk_d  = blk_q;
        held_mode_d = min_mode_q;
        held_cost_d = min_cost_q;
        if (blk_q == LastBlk) begin
          state_d = StDone;
        end else begin
          blk_d   = blk_q + 4'd1;
          state_d = StFetch;
        end
      end

      StDone: begin
        done    = 1'b1;
        state_d = StIdle;
      end

      default: state_d = StIdle;
    endcase
  end

  assign busy          = (state_q != StIdle);
  assign dp.nb_req     = nb_req;
  assign dp.nb_blk     = nb_blk;
  assign dp.nb_mb_x    = mb_x_q;
  assign dp.nb_mb_y    = mb_y_q;
  assign dp.pred_en    = pred_en;
  assign dp.pred_mode  = pred_mode;
  assign dp.best_valid = best_valid;
  assign dp.best_blk   = best_blk;
  assign dp.best_mode  = best_mode;
  assign dp.best_cost  = best_cost;

endmodule

// File: tb/tb_intra4x4_mode_sched.sv
// Bench for intra4x4_mode_sched: a negedge responder models fetcher and SAD unit from a cost
// table; a scoreboard of per-sub-block expectations is checked at every best_valid pulse.
module tb_intra4x4_mode_sched;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [6:0] mb_x;
  logic [5:0] mb_y;
  logic       busy;
  logic       done;

  intra4x4_mode_sched_if #(.COST_W(16), .MB_X_W(7), .MB_Y_W(6)) dp_if ();

  intra4x4_mode_sched dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .mb_x  (mb_x),
    .mb_y  (mb_y),
    .dp    (dp_if),
    .busy  (busy),
    .done  (done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0]  blk;
    logic [3:0]  mode;
    logic [15:0] cost;
    logic [3:0]  npred;
  } exp_t;

  exp_t        sb[$];
  exp_t        sb_ent;
  int          checks = 0;
  int          errors = 0;
  logic [15:0] ctab [16][9];

  // Responder state
  bit          resp_en   = 1'b1;
  int          ack_delay = 0;
  bit          spurious  = 1'b0;
  int          req_cnt   = 0;
  bit          pend      = 1'b0;
  logic [15:0] pend_cost = '0;
  logic [3:0]  cur_blk   = '0;

  // Monitor state
  int          pred_cnt = 0;
  int          best_cnt = 0;
  logic [3:0]  got_mode  [16];
  logic [15:0] got_cost  [16];
  int          got_npred [16];

  always @(negedge clk) begin
    if (!resp_en) begin
      pend    = 1'b0;
      req_cnt = 0;
    end else begin
      if (dp_if.nb_req === 1'b1) begin
        cur_blk      = dp_if.nb_blk;
        dp_if.nb_ack = (req_cnt == ack_delay);
        req_cnt++;
      end else begin
        dp_if.nb_ack = 1'b0;
        req_cnt      = 0;
      end
      // Cost lands in the cycle after pred_en (the WAIT cycle)
      dp_if.cost_valid = pend || (spurious && (dp_if.nb_req === 1'b1));
      dp_if.cost       = pend ? pend_cost : 16'd1;
      pend             = (dp_if.pred_en === 1'b1);
      if (pend) pend_cost = ctab[cur_blk][dp_if.pred_mode];
    end
  end

  always @(negedge clk) begin
    if (dp_if.pred_en === 1'b1) begin
      checks++;
      if (dp_if.pred_mode !== 4'(pred_cnt)) begin
        errors++;
        $display("FAIL pred_mode_seq: got %0d, expected %0d", dp_if.pred_mode, pred_cnt);
      end
      pred_cnt++;
    end
    if (dp_if.best_valid === 1'b1) begin
      best_cnt++;
      checks++;
      got_mode[dp_if.best_blk]  = dp_if.best_mode;
      got_cost[dp_if.best_blk]  = dp_if.best_cost;
      got_npred[dp_if.best_blk] = pred_cnt;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL best_unexpected: got blk %0d mode %0d cost %0d, expected no result",
                 dp_if.best_blk, dp_if.best_mode, dp_if.best_cost);
      end else begin
        sb_ent = sb.pop_front();
        if ({dp_if.best_blk, dp_if.best_mode, dp_if.best_cost, 4'(pred_cnt)} !== sb_ent) begin
          errors++;
          $display("FAIL best_result: got blk %0d mode %0d cost %0d npred %0d, expected blk %0d mode %0d cost %0d npred %0d",
                   dp_if.best_blk, dp_if.best_mode, dp_if.best_cost, pred_cnt,
                   sb_ent.blk, sb_ent.mode, sb_ent.cost, sb_ent.npred);
        end
      end
      pred_cnt = 0;
    end
  end

  function automatic exp_t model_blk(input int b);
    exp_t        e;
    logic [15:0] mc = '1;
    int          mm = 0;
    int          n  = 0;
    for (int m = 0; m < 9; m++) begin
      n++;
      if (ctab[b][m] < mc) begin
        mc = ctab[b][m];
        mm = m;
      end
`ifdef INTRA4X4_EARLY_TERM_EN
      if (ctab[b][m] < 16'd64) break;
`endif
    end
    e.blk   = 4'(b);
    e.mode  = 4'(mm);
    e.cost  = mc;
    e.npred = 4'(n);
    return e;
  endfunction

  task automatic fill_table();
    for (int b = 0; b < 16; b++)
      for (int m = 0; m < 9; m++) ctab[b][m] = 16'(100 + m);
  endtask

  task automatic push_mb();
    for (int b = 0; b < 16; b++) sb.push_back(model_blk(b));
  endtask

  // Starts one MB and waits (bounded) for done; cyc counts cycles after the accept edge
  task automatic run_mb(output int cyc, output bit ok);
    push_mb();
    best_cnt = 0;
    @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 1;
    while (done !== 1'b1 && cyc < 3000) begin
      @(posedge clk); #1;
      cyc++;
    end
    ok = (done === 1'b1);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    start = 1'b0;
    mb_x  = 7'd37;
    mb_y  = 6'd11;
    dp_if.nb_ack     = 1'b0;
    dp_if.cost_valid = 1'b0;
    dp_if.cost       = '0;
    fill_table();
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({dp_if.nb_req, dp_if.nb_blk, dp_if.nb_mb_x, dp_if.nb_mb_y, dp_if.pred_en,
         dp_if.pred_mode, dp_if.best_valid, dp_if.best_blk, dp_if.best_mode,
         dp_if.best_cost, busy, done} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got nb_req %b busy %b done %b best_cost %h, expected all zero",
               dp_if.nb_req, busy, done, dp_if.best_cost);
    end
    reset = 1'b0;
  endtask

  task automatic test_full_mb();
    int cyc;
    bit ok;
    fill_table();
    run_mb(cyc, ok);
    checks++;
    if (!ok || cyc != 321) begin
      errors++;
      $display("FAIL full_latency: got done=%b at cycle %0d, expected done at cycle 321", done, cyc);
    end
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL busy_in_done: got %b, expected 1", busy);
    end
    checks++;
    if (dp_if.nb_mb_x !== 7'd37 || dp_if.nb_mb_y !== 6'd11) begin
      errors++;
      $display("FAIL mb_latch: got %0d,%0d, expected 37,11", dp_if.nb_mb_x, dp_if.nb_mb_y);
    end
    @(posedge clk); #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL after_done: got busy %b done %b, expected 0 0", busy, done);
    end
    checks++;
    if (best_cnt != 16 || sb.size() != 0) begin
      errors++;
      $display("FAIL best_count: got %0d pulses, %0d left, expected 16 pulses, 0 left",
               best_cnt, sb.size());
    end
  endtask

  task automatic test_tie_break();
    int cyc;
    bit ok;
    fill_table();
    ctab[3] = '{16'd90, 16'd80, 16'd80, 16'd70, 16'd70, 16'd200, 16'd70, 16'd95, 16'd99};
    mb_x = 7'd79;
    mb_y = 6'd44;
    run_mb(cyc, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL tie_done: got no done after %0d cycles, expected done", cyc);
    end
    checks++;
    if (got_mode[3] !== 4'd3 || got_cost[3] !== 16'd70 || got_npred[3] != 9) begin
      errors++;
      $display("FAIL tie_break: got mode %0d cost %0d npred %0d, expected mode 3 cost 70 npred 9",
               got_mode[3], got_cost[3], got_npred[3]);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_fetch_stall();
    int cyc;
    bit ok;
    fill_table();
    ack_delay = 5;
    spurious  = 1'b1;
    push_mb();
    @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
    cyc = 1;
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (dp_if.nb_req !== 1'b1 || dp_if.nb_blk !== 4'd0 || dp_if.pred_en !== 1'b0 ||
          busy !== 1'b1) begin
        errors++;
        $display("FAIL fetch_hold_%0d: got nb_req %b nb_blk %0d pred_en %b busy %b, expected 1 0 0 1",
                 i, dp_if.nb_req, dp_if.nb_blk, dp_if.pred_en, busy);
      end
      @(posedge clk); #1;
      cyc++;
    end
    checks++;
    if (dp_if.nb_req !== 1'b0 || dp_if.pred_en !== 1'b1 || dp_if.pred_mode !== 4'd0) begin
      errors++;
      $display("FAIL fetch_release: got nb_req %b pred_en %b mode %0d, expected 0 1 0",
               dp_if.nb_req, dp_if.pred_en, dp_if.pred_mode);
    end
    start    = 1'b0;
    spurious = 1'b0;
    while (done !== 1'b1 && cyc < 3000) begin
      @(posedge clk); #1;
      cyc++;
    end
    checks++;
    if (done !== 1'b1 || cyc != 401) begin
      errors++;
      $display("FAIL stall_latency: got done=%b at cycle %0d, expected done at cycle 401", done, cyc);
    end
    ack_delay = 0;
    @(posedge clk); #1;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL stall_results: got %0d results missing, expected 0", sb.size());
    end
  endtask

  task automatic test_reset_abort();
    int  cyc;
    bit  ok;
    bit  hit = 1'b0;
    fill_table();
    push_mb();
    @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < 1000 && !hit; i++) begin
      if (dp_if.pred_en === 1'b1 && dp_if.pred_mode === 4'd4 && cur_blk == 4'd7) hit = 1'b1;
      else begin
        @(posedge clk); #1;
      end
    end
    checks++;
    if (!hit) begin
      errors++;
      $display("FAIL abort_reach: got no blk 7 mode 4 pred_en, expected one");
    end
    resp_en          = 1'b0;
    dp_if.cost_valid = 1'b0;
    dp_if.nb_ack     = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    checks++;
    if ({dp_if.nb_req, dp_if.nb_blk, dp_if.nb_mb_x, dp_if.nb_mb_y, dp_if.pred_en,
         dp_if.pred_mode, dp_if.best_valid, dp_if.best_blk, dp_if.best_mode,
         dp_if.best_cost, busy, done} !== '0) begin
      errors++;
      $display("FAIL abort_outputs: got busy %b best_blk %0d best_cost %0d nb_mb_x %0d, expected all zero",
               busy, dp_if.best_blk, dp_if.best_cost, dp_if.nb_mb_x);
    end
    reset            = 1'b0;
    dp_if.cost_valid = 1'b1;
    dp_if.cost       = 16'd1;
    @(posedge clk); #1;
    checks++;
    if (dp_if.best_valid !== 1'b0 || busy !== 1'b0 || dp_if.pred_en !== 1'b0 ||
        dp_if.nb_req !== 1'b0) begin
      errors++;
      $display("FAIL abort_late_cost: got best_valid %b busy %b pred_en %b nb_req %b, expected 0 0 0 0",
               dp_if.best_valid, busy, dp_if.pred_en, dp_if.nb_req);
    end
    dp_if.cost_valid = 1'b0;
    sb.delete();
    pred_cnt = 0;
    resp_en  = 1'b1;
    run_mb(cyc, ok);
    checks++;
    if (!ok || cyc != 321 || best_cnt != 16) begin
      errors++;
      $display("FAIL abort_restart: got done=%b at cycle %0d with %0d results, expected cycle 321 with 16",
               done, cyc, best_cnt);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_early_term();
    int cyc;
    bit ok;
    int exp_n;
`ifdef INTRA4X4_EARLY_TERM_EN
    exp_n = 3;
`else
    exp_n = 9;
`endif
    fill_table();
    ctab[5] = '{16'd100, 16'd90, 16'd40, 16'd45, 16'd70, 16'd80, 16'd90, 16'd41, 16'd40};
    run_mb(cyc, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL et_done: got no done after %0d cycles, expected done", cyc);
    end
    checks++;
    if (got_mode[5] !== 4'd2 || got_cost[5] !== 16'd40 || got_npred[5] != exp_n) begin
      errors++;
      $display("FAIL early_term: got mode %0d cost %0d npred %0d, expected mode 2 cost 40 npred %0d",
               got_mode[5], got_cost[5], got_npred[5], exp_n);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_full_mb();
    test_tie_break();
    test_fetch_stall();
    test_reset_abort();
    test_early_term();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
